// File: rtl/kb_cmd_decode.sv
// rtl/kb_cmd_decode.sv - PS/2 scan-code to BlockBlast command decoder with command FIFO
// Optional typematic repeat suppression is enabled with `define KB_REPEAT_FILTER_EN.
module kb_cmd_decode #(
    parameter int FIFO_DEPTH = 4,
    parameter int PREFIX_TO  = 2000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       NewKB,
    input  logic [7:0] KB_DAT,
    input  logic       CMD_READY,
    output logic       CMD_VALID,
    output logic [3:0] CMD,
    output logic       CMD_EXT,
    output logic       OVERFLOW
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int NW = AW + 1;
    localparam int TW = $clog2(PREFIX_TO);
    localparam logic [NW-1:0] FULL_CNT = NW'(FIFO_DEPTH);
    localparam logic [TW-1:0] TO_MAX   = TW'(PREFIX_TO - 1);
    localparam logic [7:0] PFX_EXT   = 8'hE0;
    localparam logic [7:0] PFX_BREAK = 8'hF0;

    typedef enum logic {IDLE, EXT} state_t;

    state_t        state;
    logic [TW-1:0] toCnt;
    logic          pushValid;
    logic [3:0]    pushCmd;
    logic          pushExt;

    logic       isExt;
    logic [3:0] keyCmd;
    logic       suppress;
    logic       isKey;

    // Code 0 means "no command" for the byte/prefix combination.
    function automatic logic [3:0] decodeKey(input logic [7:0] code, input logic ext);
        logic [3:0] c;
        c = 4'h0;
        if (ext) begin
            case (code)
                8'h75:   c = 4'h1;
                8'h72:   c = 4'h2;
                8'h6B:   c = 4'h3;
                8'h74:   c = 4'h4;
                default: c = 4'h0;
            endcase
        end else begin
            case (code)
                8'h16:   c = 4'h5;
                8'h1E:   c = 4'h6;
                8'h26:   c = 4'h7;
                8'h29:   c = 4'h8;
                8'h5A:   c = 4'h8;
                8'h76:   c = 4'h9;
                default: c = 4'h0;
            endcase
        end
        return c;
    endfunction

    always_comb begin
        isExt  = (state == EXT);
        keyCmd = decodeKey(KB_DAT, isExt);
        isKey  = NewKB && (KB_DAT != PFX_EXT) && (KB_DAT != PFX_BREAK);
    end

`ifdef KB_REPEAT_FILTER_EN
    logic [8:0] lastKey;

    assign suppress = (lastKey == {isExt, KB_DAT});

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            lastKey <= 9'h000;
        end else if (NewKB && KB_DAT == PFX_BREAK) begin
            lastKey <= 9'h000;
        end else if (isKey) begin
            lastKey <= {isExt, KB_DAT};
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // Prefix tracker; a decoded key is staged here one cycle before entering the FIFO.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state     <= IDLE;
            toCnt     <= '0;
            pushValid <= 1'b0;
            pushCmd   <= 4'h0;
            pushExt   <= 1'b0;
        end else begin
            pushValid <= 1'b0;
            if (NewKB) begin
                toCnt <= '0;
                if (KB_DAT == PFX_EXT) begin
                    state <= EXT;
                end else begin
                    state <= IDLE;
                    if (isKey && keyCmd != 4'h0 && !suppress) begin
                        pushValid <= 1'b1;
                        pushCmd   <= keyCmd;
                        pushExt   <= isExt;
                    end
                end
            end else if (state == EXT) begin
                if (toCnt == TO_MAX) begin
                    state <= IDLE;
                    toCnt <= '0;
                end else begin
                    toCnt <= toCnt + TW'(1);
                end
            end else begin
                toCnt <= '0;
            end
        end
    end

    logic [4:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;
    logic [NW-1:0] count;

    logic          doPop;
    logic          doPush;
    logic [AW-1:0] rdNext;
    logic [NW-1:0] countNext;
    logic [4:0]    headNext;

    always_comb begin
        doPop     = CMD_VALID && CMD_READY;
        doPush    = pushValid && ((count != FULL_CNT) || doPop);
        rdNext    = doPop ? rdPtr + AW'(1) : rdPtr;
        countNext = count;
        if (doPush && !doPop) begin
            countNext = count + NW'(1);
        end else if (doPop && !doPush) begin
            countNext = count - NW'(1);
        end
        // The incoming entry becomes head when it lands in the slot being exposed next.
        if (doPush && wrPtr == rdNext) begin
            headNext = {pushExt, pushCmd};
        end else begin
            headNext = mem[rdNext];
        end
    end

    always_ff @(posedge CLK) begin
        if (doPush) begin
            mem[wrPtr] <= {pushExt, pushCmd};
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            CMD_VALID <= 1'b0;
            CMD       <= 4'h0;
            CMD_EXT   <= 1'b0;
            OVERFLOW  <= 1'b0;
        end else begin
            rdPtr     <= rdNext;
            count     <= countNext;
            CMD_VALID <= (countNext != '0);
            if (doPush) begin
                wrPtr <= wrPtr + AW'(1);
            end
            if (countNext != '0) begin
                {CMD_EXT, CMD} <= headNext;
            end
            if (pushValid && !doPush) begin
                OVERFLOW <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_kb_cmd_decode.sv
// tb/tb_kb_cmd_decode.sv - directed self-checking bench for kb_cmd_decode
module tb_kb_cmd_decode;

    localparam int DEPTH = 4;
    localparam int PTO   = 16;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic       NewKB = 1'b0;
    logic [7:0] KB_DAT = 8'h00;
    logic       CMD_READY = 1'b0;
    logic       CMD_VALID;
    logic [3:0] CMD;
    logic       CMD_EXT;
    logic       OVERFLOW;

    int passCnt = 0;
    int totalCnt = 0;
    logic [4:0] seen[$];

    kb_cmd_decode #(.FIFO_DEPTH(DEPTH), .PREFIX_TO(PTO)) dut (
        .CLK(CLK), .RESET(RESET), .NewKB(NewKB), .KB_DAT(KB_DAT),
        .CMD_READY(CMD_READY), .CMD_VALID(CMD_VALID), .CMD(CMD),
        .CMD_EXT(CMD_EXT), .OVERFLOW(OVERFLOW)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (RESET && CMD_VALID && CMD_READY) seen.push_back({CMD_EXT, CMD});
    end

    task automatic sendByte(input logic [7:0] b);
        @(posedge CLK); #1;
        NewKB = 1'b1;
        KB_DAT = b;
        @(posedge CLK); #1;
        NewKB = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic test_reset;
        totalCnt++; if (CMD_VALID !== 1'b0) $display("FAIL reset_valid got %b want 0", CMD_VALID); else passCnt++;
        totalCnt++; if (CMD !== 4'h0) $display("FAIL reset_cmd got %h want 0", CMD); else passCnt++;
        totalCnt++; if (CMD_EXT !== 1'b0) $display("FAIL reset_ext got %b want 0", CMD_EXT); else passCnt++;
        totalCnt++; if (OVERFLOW !== 1'b0) $display("FAIL reset_ovf got %b want 0", OVERFLOW); else passCnt++;
    endtask

    task automatic test_basic;
        CMD_READY = 1'b1;
        seen.delete();
        sendByte(8'h16);
        totalCnt++; if (CMD_VALID !== 1'b0) $display("FAIL lat_early got %b want 0", CMD_VALID); else passCnt++;
        idle(1);
        totalCnt++; if (CMD_VALID !== 1'b1) $display("FAIL lat_valid got %b want 1", CMD_VALID); else passCnt++;
        totalCnt++; if (CMD !== 4'h5) $display("FAIL lat_cmd got %h want 5", CMD); else passCnt++;
        sendByte(8'h29);
        idle(4);
        totalCnt++; if (seen.size() != 2) $display("FAIL basic_count got %0d want 2", seen.size()); else passCnt++;
        if (seen.size() == 2) begin
            totalCnt++; if (seen[0] !== 5'h05) $display("FAIL basic_first got %h want 05", seen[0]); else passCnt++;
            totalCnt++; if (seen[1] !== 5'h08) $display("FAIL basic_second got %h want 08", seen[1]); else passCnt++;
        end
        totalCnt++; if (OVERFLOW !== 1'b0) $display("FAIL basic_ovf got %b want 0", OVERFLOW); else passCnt++;
    endtask

    task automatic test_ext;
        CMD_READY = 1'b1;
        seen.delete();
        sendByte(8'hE0); sendByte(8'h75); sendByte(8'hE0); sendByte(8'hF0); sendByte(8'h75);
        idle(5);
        totalCnt++; if (seen.size() != 1) $display("FAIL ext_count got %0d want 1", seen.size()); else passCnt++;
        if (seen.size() >= 1) begin
            totalCnt++; if (seen[0] !== 5'h11) $display("FAIL ext_entry got %h want 11", seen[0]); else passCnt++;
        end
    endtask

    task automatic test_overflow;
        logic [4:0] expv[4] = '{5'h05, 5'h06, 5'h07, 5'h08};
        CMD_READY = 1'b0;
        seen.delete();
        sendByte(8'h16); sendByte(8'h1E); sendByte(8'h26); sendByte(8'h29); sendByte(8'h76);
        idle(3);
        totalCnt++; if (CMD_VALID !== 1'b1) $display("FAIL full_valid got %b want 1", CMD_VALID); else passCnt++;
        totalCnt++; if (CMD !== 4'h5) $display("FAIL full_head got %h want 5", CMD); else passCnt++;
        totalCnt++; if (OVERFLOW !== 1'b1) $display("FAIL full_ovf got %b want 1", OVERFLOW); else passCnt++;
        CMD_READY = 1'b1;
        idle(8);
        totalCnt++; if (seen.size() != 4) $display("FAIL drain_count got %0d want 4", seen.size()); else passCnt++;
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            totalCnt++; if (seen[i] !== expv[i]) $display("FAIL drain_%0d got %h want %h", i, seen[i], expv[i]); else passCnt++;
        end
        totalCnt++; if (CMD_VALID !== 1'b0) $display("FAIL drain_valid got %b want 0", CMD_VALID); else passCnt++;
        totalCnt++; if (OVERFLOW !== 1'b1) $display("FAIL ovf_sticky got %b want 1", OVERFLOW); else passCnt++;
    endtask

    task automatic test_timeout;
        CMD_READY = 1'b1;
        seen.delete();
        sendByte(8'hE0); idle(PTO); sendByte(8'h75);
        idle(5);
        totalCnt++; if (seen.size() != 0) $display("FAIL to_expired got %0d cmds want 0", seen.size()); else passCnt++;
        sendByte(8'hE0); idle(PTO - 4); sendByte(8'h75);
        idle(5);
        totalCnt++; if (seen.size() != 1) $display("FAIL to_alive_count got %0d want 1", seen.size()); else passCnt++;
        if (seen.size() >= 1) begin
            totalCnt++; if (seen[0] !== 5'h11) $display("FAIL to_alive_entry got %h want 11", seen[0]); else passCnt++;
        end
    endtask

    task automatic test_repeat;
        int n3;
        int want;
        logic [7:0] seq[14] = '{8'h6B, 8'h6B, 8'h6B, 8'hF0, 8'h6B,
                                8'hE0, 8'h6B, 8'hE0, 8'h6B, 8'hE0, 8'h6B,
                                8'hE0, 8'hF0, 8'hE0};
        CMD_READY = 1'b1;
        seen.delete();
        for (int i = 0; i < 14; i++) sendByte(seq[i]);
        sendByte(8'h6B);
        idle(5);
        n3 = 0;
        foreach (seen[i]) if (seen[i] == 5'h13) n3++;
`ifdef KB_REPEAT_FILTER_EN
        want = 2;
`else
        want = 4;
`endif
        totalCnt++; if (n3 != want) $display("FAIL repeat_count got %0d want %0d", n3, want); else passCnt++;
        totalCnt++; if (seen.size() != want) $display("FAIL repeat_total got %0d want %0d", seen.size(), want); else passCnt++;
    endtask

    task automatic test_reset_mid;
        CMD_READY = 1'b0;
        sendByte(8'h16); sendByte(8'h1E); sendByte(8'hE0);
        totalCnt++; if (CMD_VALID !== 1'b1) $display("FAIL mid_pre_valid got %b want 1", CMD_VALID); else passCnt++;
        #2 RESET = 1'b0;
        #1;
        totalCnt++; if (CMD_VALID !== 1'b0) $display("FAIL mid_valid got %b want 0", CMD_VALID); else passCnt++;
        totalCnt++; if (OVERFLOW !== 1'b0) $display("FAIL mid_ovf got %b want 0", OVERFLOW); else passCnt++;
        @(posedge CLK); #1 RESET = 1'b1;
        seen.delete();
        CMD_READY = 1'b1;
        sendByte(8'h29);
        idle(4);
        totalCnt++; if (seen.size() != 1) $display("FAIL mid_after_count got %0d want 1", seen.size()); else passCnt++;
        if (seen.size() >= 1) begin
            totalCnt++; if (seen[0] !== 5'h08) $display("FAIL mid_after_entry got %h want 08", seen[0]); else passCnt++;
        end
    endtask

    initial begin
        #12;
        test_reset;
        @(posedge CLK); #1 RESET = 1'b1;
        test_basic;
        test_ext;
        test_overflow;
        test_timeout;
        test_repeat;
        test_reset_mid;
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
